router_pkt_tx: RTL and testbench

- Packet source for the 1x3 router input port.
- Accepts a command (destination address, payload length) and the payload bytes from a host, then stores the payload in an internal 64x8 buffer.
- Serialises the packet onto the router input as header, payload and parity byte, driving pkt_valid and honouring the router busy back-pressure.
- Drives the router input in system-level and emulation benches, and acts as the transmit side of the router protocol.

---
 rtl/router_pkt_tx.sv | 191 +++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// -----------------------------------------------------------------------------
// router_pkt_tx
// Packet source for one input port of the 1x3 router. A host issues a command
// (destination address, payload length) and then writes the payload bytes into
// a 64x8 buffer. Once the buffer holds the whole payload, the block serialises
// header, payload and parity onto the router input and honours router busy.
//
// Ports
//   clock          in   1  system clock, rising edge
//   reset          in   1  asynchronous, active-high reset
//   start          in   1  command strobe, sampled only in IDLE
//   addr           in   2  destination port 0..2 (3 is illegal)
//   len            in   6  payload length 1..63 (0 is illegal)
//   corrupt_parity in   1  latched with the command, inverts the parity byte
//   cmd_ready      out  1  high in IDLE
//   wr_en          in   1  payload byte write strobe
//   wr_data        in   8  payload byte
//   wr_ready       out  1  high in LOAD
//   busy           in   1  router back-pressure, holds the current byte
//   pkt_data       out  8  registered byte toward router data_in
//   pkt_valid      out  1  registered, high for header and payload bytes
//   tx_done        out  1  one-cycle pulse after the parity byte is accepted
//   cmd_err        out  1  one-cycle pulse after an illegal command
//   tx_active      out  1  high whenever the block is not IDLE
// -----------------------------------------------------------------------------
module router_pkt_tx #(
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] addr,
   input  logic [5:0] len,
   input  logic       corrupt_parity,
   output logic       cmd_ready,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       wr_ready,
   input  logic       busy,
   output logic [7:0] pkt_data,
   output logic       pkt_valid,
   output logic       tx_done,
   output logic       cmd_err,
   output logic       tx_active
);

   // Gap counter holds GAP_CYCLES-1 at most; keep at least one bit.
   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : {GW{1'b0}};
   localparam logic [GW-1:0] GCNT_ONE = GW'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_HEADER  = 3'd2,
      S_PAYLOAD = 3'd3,
      S_PARITY  = 3'd4,
      S_GAP     = 3'd5
   } state_t;

   state_t        state_r;
   logic [1:0]    addr_r;
   logic [5:0]    len_r;
   logic          corrupt_r;
   logic [7:0]    parity_r;
   logic [5:0]    wcnt_r;
   logic [5:0]    rcnt_r;
   logic [GW-1:0] gcnt_r;
   logic [7:0]    buf_mem [0:63];

   // Header layout: length in the upper six bits, destination in the lower two.
   function automatic logic [7:0] make_header(input logic [5:0] l, input logic [1:0] a);
      return {l, a};
   endfunction

   // A command is legal when it names a real port and carries at least one byte.
   function automatic logic cmd_legal(input logic [1:0] a, input logic [5:0] l);
      return (a != 2'd3) && (l != 6'd0);
   endfunction

   // Running even-parity accumulator over header and payload bytes.
   function automatic logic [7:0] parity_acc(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

   assign cmd_ready = (state_r == S_IDLE);
   assign wr_ready  = (state_r == S_LOAD);
   assign tx_active = (state_r != S_IDLE);

   // Payload buffer write port; contents need no reset.
   always_ff @(posedge clock) begin
      if ((state_r == S_LOAD) && wr_en) begin
         buf_mem[wcnt_r] <= wr_data;
      end
   end

   // Command, load and transmit sequencer with registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r   <= S_IDLE;
         addr_r    <= 2'd0;
         len_r     <= 6'd0;
         corrupt_r <= 1'b0;
         parity_r  <= 8'd0;
         wcnt_r    <= 6'd0;
         rcnt_r    <= 6'd0;
         gcnt_r    <= {GW{1'b0}};
         pkt_data  <= 8'd0;
         pkt_valid <= 1'b0;
         tx_done   <= 1'b0;
         cmd_err   <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         cmd_err <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  if (cmd_legal(addr, len)) begin
                     addr_r    <= addr;
                     len_r     <= len;
                     corrupt_r <= corrupt_parity;
                     parity_r  <= make_header(len, addr);
                     wcnt_r    <= 6'd0;
                     state_r   <= S_LOAD;
                  end else begin
                     cmd_err <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (wr_en) begin
                  parity_r <= parity_acc(parity_r, wr_data);
                  wcnt_r   <= wcnt_r + 6'd1;
                  // Last byte stored: the header goes out on the next cycle.
                  if (wcnt_r == (len_r - 6'd1)) begin
                     pkt_data  <= make_header(len_r, addr_r);
                     pkt_valid <= 1'b1;
                     rcnt_r    <= 6'd0;
                     state_r   <= S_HEADER;
                  end
               end
            end
            S_HEADER: begin
               if (!busy) begin
                  pkt_data <= buf_mem[6'd0];
                  rcnt_r   <= 6'd1;
                  state_r  <= S_PAYLOAD;
               end
            end
            S_PAYLOAD: begin
               if (!busy) begin
                  // rcnt is the index of the next byte to present.
                  if (rcnt_r < len_r) begin
                     pkt_data <= buf_mem[rcnt_r];
                     rcnt_r   <= rcnt_r + 6'd1;
                  end else begin
                     pkt_data  <= parity_r ^ {8{corrupt_r}};
                     pkt_valid <= 1'b0;
                     state_r   <= S_PARITY;
                  end
               end
            end
            S_PARITY: begin
               if (!busy) begin
                  pkt_data <= 8'd0;
                  tx_done  <= 1'b1;
                  if (GAP_CYCLES > 0) begin
                     gcnt_r  <= GAP_LOAD;
                     state_r <= S_GAP;
                  end else begin
                     state_r <= S_IDLE;
                  end
               end
            end
            S_GAP: begin
               if (gcnt_r == {GW{1'b0}}) begin
                  state_r <= S_IDLE;
               end else begin
                  gcnt_r <= gcnt_r - GCNT_ONE;
               end
            end
            default: begin
               state_r   <= S_IDLE;
               pkt_data  <= 8'd0;
               pkt_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_router_pkt_tx.sv
// -----------------------------------------------------------------------------
// tb_router_pkt_tx
// Self-checking bench for router_pkt_tx. Each packet's expected output stream
// (header, payload, parity with valid flags) is built from the command as a
// queue and compared byte by byte, with busy driven randomly or in a fixed
// burst. Directed cases cover the listed scenarios; a random loop follows.
// -----------------------------------------------------------------------------
module tb_router_pkt_tx;

   localparam int GAP = 2;

   logic       clock;
   logic       reset;
   logic       start;
   logic [1:0] addr;
   logic [5:0] len;
   logic       corrupt_parity;
   logic       cmd_ready;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       busy;
   logic [7:0] pkt_data;
   logic       pkt_valid;
   logic       tx_done;
   logic       cmd_err;
   logic       tx_active;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] pay [0:63];

   router_pkt_tx #(.GAP_CYCLES(GAP)) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .addr           (addr),
      .len            (len),
      .corrupt_parity (corrupt_parity),
      .cmd_ready      (cmd_ready),
      .wr_en          (wr_en),
      .wr_data        (wr_data),
      .wr_ready       (wr_ready),
      .busy           (busy),
      .pkt_data       (pkt_data),
      .pkt_valid      (pkt_valid),
      .tx_done        (tx_done),
      .cmd_err        (cmd_err),
      .tx_active      (tx_active)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Issue an illegal command and expect only a cmd_err pulse.
   task automatic illegal_cmd(input logic [1:0] a, input logic [5:0] l);
      start = 1'b1; addr = a; len = l; corrupt_parity = 1'($urandom);
      @(negedge clock);
      start = 1'b0;
      check_eq("cmd_err_pulse", 32'(cmd_err), 32'd1);
      check_eq("cmd_ready_err", 32'(cmd_ready), 32'd1);
      check_eq("pkt_valid_err", 32'(pkt_valid), 32'd0);
      check_eq("tx_active_err", 32'(tx_active), 32'd0);
      @(negedge clock);
      check_eq("cmd_err_end", 32'(cmd_err), 32'd0);
      check_eq("cmd_ready_after", 32'(cmd_ready), 32'd1);
   endtask

   // Send one packet whose payload is pay[0..l-1] and check the whole stream.
   // busy_idx/busy_len force a busy burst on one stream position; abort_idx
   // (>=0) asserts reset when that stream position is on the output.
   task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input logic cp,
                           input int busy_pct, input int busy_idx, input int busy_len,
                           input int abort_idx);
      logic [7:0] exp_q [$];
      logic       exp_v [$];
      logic [7:0] par;
      logic       b;
      int         n, idx, held, guard, cnt;

      // Reference stream: header, payload in order, then (possibly inverted) parity.
      par = {l, a};
      exp_q.push_back({l, a});
      exp_v.push_back(1'b1);
      for (int k = 0; k < int'(l); k++) begin
         exp_q.push_back(pay[k]);
         exp_v.push_back(1'b1);
         par = par ^ pay[k];
      end
      if (cp) par = par ^ 8'hFF;
      exp_q.push_back(par);
      exp_v.push_back(1'b0);
      n = exp_q.size();

      check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      start = 1'b1; addr = a; len = l; corrupt_parity = cp;
      @(negedge clock);
      start = 1'b0;
      check_eq("cmd_ready_load", 32'(cmd_ready), 32'd0);
      check_eq("tx_active_load", 32'(tx_active), 32'd1);

      for (int k = 0; k < int'(l); k++) begin
         repeat ($urandom_range(0, 2)) begin
            wr_en = 1'b0; start = 1'b1; busy = 1'($urandom);
            @(negedge clock);
         end
         check_eq("wr_ready_load", 32'(wr_ready), 32'd1);
         check_eq("pkt_valid_load", 32'(pkt_valid), 32'd0);
         wr_en = 1'b1; wr_data = pay[k]; start = 1'($urandom); busy = 1'($urandom);
         @(negedge clock);
      end
      wr_en = 1'b0; start = 1'b0;
      check_eq("wr_ready_tx", 32'(wr_ready), 32'd0);

      idx = 0; held = 0; guard = 0;
      while (idx < n && guard < 2000) begin
         if (idx == abort_idx) begin
            #1 reset = 1'b1;
            #1;
            check_eq("rst_pkt_valid", 32'(pkt_valid), 32'd0);
            check_eq("rst_pkt_data", 32'(pkt_data), 32'd0);
            check_eq("rst_tx_active", 32'(tx_active), 32'd0);
            check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
            busy = 1'b0; start = 1'b0; wr_en = 1'b0;
            @(negedge clock);
            reset = 1'b0;
            @(negedge clock);
            return;
         end
         check_eq("pkt_data", 32'(pkt_data), 32'(exp_q[idx]));
         check_eq("pkt_valid", 32'(pkt_valid), 32'(exp_v[idx]));
         check_eq("tx_done_low", 32'(tx_done), 32'd0);
         check_eq("tx_active_tx", 32'(tx_active), 32'd1);
         if (idx == busy_idx && held < busy_len) begin
            b = 1'b1;
            held++;
         end else begin
            b = ($urandom_range(0, 99) < busy_pct);
         end
         busy = b; wr_en = 1'($urandom); wr_data = 8'($urandom); start = 1'($urandom);
         @(negedge clock);
         if (!b) idx++;
         guard++;
      end
      busy = 1'b0; wr_en = 1'b0; start = 1'b0;
      check_eq("stream_complete", 32'(idx), 32'(n));
      check_eq("tx_done_pulse", 32'(tx_done), 32'd1);
      check_eq("pkt_valid_end", 32'(pkt_valid), 32'd0);
      check_eq("pkt_data_end", 32'(pkt_data), 32'd0);

      // tx_active stays high for GAP cycles counted from the tx_done cycle.
      cnt = 0;
      while (tx_active && cnt < 100) begin
         check_eq("pkt_data_gap", 32'(pkt_data), 32'd0);
         cnt++;
         @(negedge clock);
      end
      check_eq("gap_len", 32'(cnt), 32'(GAP));
      check_eq("cmd_ready_back", 32'(cmd_ready), 32'd1);
      @(negedge clock);
      check_eq("tx_done_single", 32'(tx_done), 32'd0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; addr = 2'd0; len = 6'd0; corrupt_parity = 1'b0;
      wr_en = 1'b0; wr_data = 8'd0; busy = 1'b0;
      repeat (2) @(negedge clock);
      check_eq("reset_pkt_data", 32'(pkt_data), 32'd0);
      check_eq("reset_pkt_valid", 32'(pkt_valid), 32'd0);
      check_eq("reset_tx_done", 32'(tx_done), 32'd0);
      check_eq("reset_cmd_err", 32'(cmd_err), 32'd0);
      check_eq("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      check_eq("reset_wr_ready", 32'(wr_ready), 32'd0);
      check_eq("reset_tx_active", 32'(tx_active), 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // Basic packet: 0D 11 22 33 then parity 0D.
      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
      send_pkt(2'd1, 6'd3, 1'b0, 0, -1, 0, -1);
      // Same packet with busy held 2 cycles while 22 is presented.
      send_pkt(2'd1, 6'd3, 1'b0, 0, 2, 2, -1);

      illegal_cmd(2'd1, 6'd0);
      illegal_cmd(2'd3, 6'd5);

      // Maximum length packet, header FE.
      for (int k = 0; k < 63; k++) pay[k] = 8'(k);
      send_pkt(2'd2, 6'd63, 1'b0, 0, -1, 0, -1);

      // Corrupted parity: F2.
      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
      send_pkt(2'd1, 6'd3, 1'b1, 0, -1, 0, -1);

      // Reset while a payload byte is on the output, then a fresh packet.
      for (int k = 0; k < 10; k++) pay[k] = 8'($urandom);
      send_pkt(2'd0, 6'd10, 1'b0, 20, -1, 0, 4);
      pay[0] = 8'hAA;
      send_pkt(2'd0, 6'd1, 1'b0, 0, -1, 0, -1);

      // Random traffic.
      for (int t = 0; t < 20; t++) begin
         if ($urandom_range(0, 4) == 0) begin
            if ($urandom_range(0, 1) == 1) illegal_cmd(2'd3, 6'($urandom_range(0, 63)));
            else                           illegal_cmd(2'($urandom_range(0, 2)), 6'd0);
         end else begin
            for (int k = 0; k < 64; k++) pay[k] = 8'($urandom);
            send_pkt(2'($urandom_range(0, 2)), 6'($urandom_range(1, 63)), 1'($urandom),
                     int'($urandom_range(0, 60)), -1, 0, -1);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
